// File: rtl/game_sequencer_if.sv
// -----------------------------------------------------------------------------
// game_sequencer_if
// Bundles the game-flow controller's inputs (frame pulse, button, level
// switch, collision flags) and its registered control/status outputs.
//   master : drives update/start/levelselect/hit/goal, observes the status
//   slave  : the sequencer itself
// Signals:
//   update       frame-update pulse, one clk wide
//   start        synchronised start button level
//   levelselect  level switch (0 = level 1, 1 = level 2)
//   hit, goal    collision flags
//   state        0 IDLE, 1 PLAY, 2 RESPAWN, 3 WIN, 4 LOSE
//   level        level latched at game start
//   play_en      high only in PLAY
//   player_rst   one-clk pulse returning the player to the start position
//   lives        remaining lives
//   seconds      remaining time in seconds
//   show_win     high in WIN
//   show_over    high in LOSE
// -----------------------------------------------------------------------------
interface game_sequencer_if;
  logic       update;
  logic       start;
  logic       levelselect;
  logic       hit;
  logic       goal;
  logic [2:0] state;
  logic       level;
  logic       play_en;
  logic       player_rst;
  logic [2:0] lives;
  logic [7:0] seconds;
  logic       show_win;
  logic       show_over;

  modport master (
    output update, start, levelselect, hit, goal,
    input  state, level, play_en, player_rst, lives, seconds, show_win, show_over
  );

  modport slave (
    input  update, start, levelselect, hit, goal,
    output state, level, play_en, player_rst, lives, seconds, show_win, show_over
  );
endinterface

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Game-flow controller for the maze game. Steps through IDLE, PLAY, RESPAWN,
// WIN and LOSE, and owns the lives counter, the countdown timer and the
// latched level number. Every output is a register.
// Ports:
//   clk     pixel clock, all logic on the rising edge
//   rst     synchronous active-high reset
//   bus_if  game_sequencer_if.slave (inputs and status outputs)
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned LIVES          = 3,
  parameter int unsigned TIME_LIMIT     = 90,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES    = 120
) (
  input  logic                   clk,
  input  logic                   rst,
  game_sequencer_if.slave        bus_if
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_WIN     = 3'd3,
    ST_LOSE    = 3'd4
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] TIME_INIT  = 8'(TIME_LIMIT);
  localparam logic [7:0] FPS_LAST   = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] RESP_LAST  = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] HOLD_MAX   = 8'(HOLD_FRAMES);

  state_e     state_q, state_d;
  logic       start_q;
  logic       level_q, level_d;
  logic       player_rst_q, player_rst_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] seconds_q, seconds_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] resp_cnt_q, resp_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       play_en_q, show_win_q, show_over_q;
  logic       start_evt;

  // Rising edge of the button against its registered copy.
  assign start_evt = bus_if.start & ~start_q;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    seconds_d    = seconds_q;
    frame_cnt_d  = frame_cnt_q;
    resp_cnt_d   = resp_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    player_rst_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        level_d = bus_if.levelselect;
        if (start_evt) begin
          lives_d      = LIVES_INIT;
          seconds_d    = TIME_INIT;
          frame_cnt_d  = '0;
          player_rst_d = 1'b1;
          state_d      = ST_PLAY;
        end
      end

      ST_PLAY: begin
        // goal beats hit, and both pre-empt the timer tick of the same clk.
        if (bus_if.goal) begin
          hold_cnt_d = '0;
          state_d    = ST_WIN;
        end else if (bus_if.hit) begin
          if (lives_q > 3'd1) begin
            lives_d    = lives_q - 3'd1;
            resp_cnt_d = '0;
            state_d    = ST_RESPAWN;
          end else begin
            lives_d    = '0;
            hold_cnt_d = '0;
            state_d    = ST_LOSE;
          end
        end else if (bus_if.update) begin
          if (frame_cnt_q == FPS_LAST) begin
            frame_cnt_d = '0;
            if (seconds_q != 8'd0) begin
              seconds_d = seconds_q - 8'd1;
            end
            // Decrementing from 1 (or a stray 0) ends the game.
            if (seconds_q <= 8'd1) begin
              hold_cnt_d = '0;
              state_d    = ST_LOSE;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      ST_RESPAWN: begin
        // Player is reset on exit so the crash position stays on screen.
        if (bus_if.update) begin
          if (resp_cnt_q == RESP_LAST) begin
            player_rst_d = 1'b1;
            state_d      = ST_PLAY;
          end else begin
            resp_cnt_d = resp_cnt_q + 8'd1;
          end
        end
      end

      ST_WIN, ST_LOSE: begin
        if (start_evt && (hold_cnt_q == HOLD_MAX)) begin
          state_d = ST_IDLE;
        end else if (bus_if.update && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      // Treat the button as already pressed so a press held through reset
      // needs a release before it can start a game.
      start_q      <= 1'b1;
      level_q      <= 1'b0;
      player_rst_q <= 1'b1;
      lives_q      <= LIVES_INIT;
      seconds_q    <= TIME_INIT;
      frame_cnt_q  <= '0;
      resp_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      play_en_q    <= 1'b0;
      show_win_q   <= 1'b0;
      show_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus_if.start;
      level_q      <= level_d;
      player_rst_q <= player_rst_d;
      lives_q      <= lives_d;
      seconds_q    <= seconds_d;
      frame_cnt_q  <= frame_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      play_en_q    <= (state_d == ST_PLAY);
      show_win_q   <= (state_d == ST_WIN);
      show_over_q  <= (state_d == ST_LOSE);
    end
  end

  assign bus_if.state      = state_q;
  assign bus_if.level      = level_q;
  assign bus_if.play_en    = play_en_q;
  assign bus_if.player_rst = player_rst_q;
  assign bus_if.lives      = lives_q;
  assign bus_if.seconds    = seconds_q;
  assign bus_if.show_win   = show_win_q;
  assign bus_if.show_over  = show_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
// Directed scenarios followed by randomized play, every clk compared against
// a behavioural model of the game rules kept in this bench.
// -----------------------------------------------------------------------------
module tb_game_sequencer;
  localparam int LIVES = 3;
  localparam int TL    = 90;
  localparam int FPS   = 60;
  localparam int RF    = 60;
  localparam int HF    = 120;

  localparam int S_IDLE = 0, S_PLAY = 1, S_RESP = 2, S_WIN = 3, S_LOSE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  game_sequencer_if bus();

  game_sequencer #(
    .LIVES(LIVES), .TIME_LIMIT(TL), .FRAMES_PER_SEC(FPS),
    .RESPAWN_FRAMES(RF), .HOLD_FRAMES(HF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic start_v = 1'b0;
  logic ls_v = 1'b0;

  // Model: time is kept as total play updates since game start.
  int   m_state, m_lives, m_elapsed, m_resp, m_hold;
  logic m_level, m_prst, m_prev;

  function automatic int m_secs();
    return TL - (m_elapsed / FPS);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      if (errors <= 50)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic u, input logic h, input logic g, input logic r);
    logic evt;
    if (r) begin
      m_state = S_IDLE; m_level = 1'b0; m_prst = 1'b1; m_lives = LIVES;
      m_elapsed = 0; m_resp = 0; m_hold = 0; m_prev = 1'b1;
    end else begin
      evt = start_v && !m_prev;
      m_prev = start_v;
      m_prst = 1'b0;
      case (m_state)
        S_IDLE: begin
          m_level = ls_v;
          if (evt) begin
            m_lives = LIVES; m_elapsed = 0; m_prst = 1'b1; m_state = S_PLAY;
          end
        end
        S_PLAY: begin
          if (g) begin
            m_hold = 0; m_state = S_WIN;
          end else if (h) begin
            if (m_lives > 1) begin
              m_lives--; m_resp = 0; m_state = S_RESP;
            end else begin
              m_lives = 0; m_hold = 0; m_state = S_LOSE;
            end
          end else if (u) begin
            m_elapsed++;
            if (m_secs() == 0) begin
              m_hold = 0; m_state = S_LOSE;
            end
          end
        end
        S_RESP: begin
          if (u) begin
            m_resp++;
            if (m_resp == RF) begin
              m_prst = 1'b1; m_state = S_PLAY;
            end
          end
        end
        default: begin
          if (evt && m_hold == HF) m_state = S_IDLE;
          else if (u && m_hold < HF) m_hold++;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("state",      int'(bus.state),      m_state);
    check("level",      int'(bus.level),      int'(m_level));
    check("play_en",    int'(bus.play_en),    int'(m_state == S_PLAY));
    check("player_rst", int'(bus.player_rst), int'(m_prst));
    check("lives",      int'(bus.lives),      m_lives);
    check("seconds",    int'(bus.seconds),    m_secs());
    check("show_win",   int'(bus.show_win),   int'(m_state == S_WIN));
    check("show_over",  int'(bus.show_over),  int'(m_state == S_LOSE));
  endtask

  task automatic tick(input logic u, input logic h, input logic g, input logic r);
    @(negedge clk);
    bus.update = u; bus.hit = h; bus.goal = g;
    bus.start = start_v; bus.levelselect = ls_v; rst = r;
    @(posedge clk);
    model_step(u, h, g, r);
    #1;
    compare_all();
  endtask

  task automatic updates(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    start_v = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
    start_v = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic note(input string what);
    $display("[%0t] %s: state=%0d lives=%0d seconds=%0d level=%0d",
             $time, what, bus.state, bus.lives, bus.seconds, bus.level);
  endtask

  initial begin
    bus.update = 1'b0; bus.hit = 1'b0; bus.goal = 1'b0;
    bus.start = 1'b0; bus.levelselect = 1'b0;

    // Reset values
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_state", int'(bus.state), 0);
    check("rst_prst", int'(bus.player_rst), 1);
    check("rst_lives", int'(bus.lives), 3);
    check("rst_secs", int'(bus.seconds), 90);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("prst_clear", int'(bus.player_rst), 0);
    note("reset");

    // Game start latches level
    ls_v = 1'b1;
    press_start();
    check("go_state", int'(bus.state), 1);
    check("go_prst", int'(bus.player_rst), 1);
    check("go_lives", int'(bus.lives), 3);
    check("go_secs", int'(bus.seconds), 90);
    check("go_level", int'(bus.level), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("prst_one_clk", int'(bus.player_rst), 0);
    ls_v = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("level_frozen", int'(bus.level), 1);
    start_v = 1'b0;
    note("start");

    // One timer second
    updates(60);
    check("secs_89", int'(bus.seconds), 89);
    note("one second");

    // Three hits
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("hit1_state", int'(bus.state), 2);
    check("hit1_lives", int'(bus.lives), 2);
    updates(59);
    check("resp_wait", int'(bus.state), 2);
    updates(1);
    check("resp_exit_state", int'(bus.state), 1);
    check("resp_exit_prst", int'(bus.player_rst), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("hit2_lives", int'(bus.lives), 1);
    updates(60);
    check("resp2_exit", int'(bus.state), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("hit3_state", int'(bus.state), 4);
    check("hit3_lives", int'(bus.lives), 0);
    note("three hits");
    updates(HF);
    press_start();
    check("lose_to_idle", int'(bus.state), 0);
    note("back to idle");

    // Timer expiry
    press_start();
    start_v = 1'b0;
    updates(TL * FPS - 1);
    check("expiry_pre_state", int'(bus.state), 1);
    check("expiry_pre_secs", int'(bus.seconds), 1);
    updates(1);
    check("expiry_state", int'(bus.state), 4);
    check("expiry_secs", int'(bus.seconds), 0);
    check("expiry_over", int'(bus.show_over), 1);
    note("timer expiry");
    updates(HF);
    press_start();
    start_v = 1'b0;

    // goal beats hit with one life left
    press_start();
    start_v = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    updates(RF);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    updates(RF);
    check("one_life", int'(bus.lives), 1);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("hitgoal_state", int'(bus.state), 3);
    check("hitgoal_lives", int'(bus.lives), 1);
    check("hitgoal_win", int'(bus.show_win), 1);
    note("hit+goal");

    // WIN hold period
    updates(50);
    start_v = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("win_early_start", int'(bus.state), 3);
    start_v = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
    updates(70);
    start_v = 1'b1; tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("win_to_idle", int'(bus.state), 0);
    note("win hold");

    // Reset mid-respawn with start held
    press_start();
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    updates(10);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_state", int'(bus.state), 0);
    check("midrst_lives", int'(bus.lives), 3);
    check("midrst_secs", int'(bus.seconds), 90);
    check("midrst_play_en", int'(bus.play_en), 0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_no_start", int'(bus.state), 0);
    press_start();
    check("restart_state", int'(bus.state), 1);
    note("reset mid-respawn");

    // Randomized play
    for (int i = 0; i < 20000; i++) begin
      logic [2:0] prev_state;
      prev_state = bus.state;
      if ($urandom_range(0, 39) == 0) start_v = ~start_v;
      if ($urandom_range(0, 29) == 0) ls_v = ~ls_v;
      tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 2999) == 0));
      if (bus.state != prev_state) note("random transition");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game-flow controller for the maze game. It sequences the player, collision and display paths through the IDLE, PLAY, RESPAWN, WIN and LOSE phases. It also owns the lives counter, the countdown timer and the latched level number. The VGA colour mux and the player block take their mode, freeze and restart controls from this block instead of reading the raw collision flags and levelselect switch.

Parameters:
LIVES, 3, lives loaded on game start (1..7)
TIME_LIMIT, 90, countdown in seconds loaded on game start (1..255)
FRAMES_PER_SEC, 60, update pulses per timer second (1..255)
RESPAWN_FRAMES, 60, update pulses spent frozen in RESPAWN (1..255)
HOLD_FRAMES, 120, update pulses in WIN/LOSE before start is accepted (1..255)

Ports:
clk  in  1  VGA pixel clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
update  in  1  frame-update pulse, one clk wide
start  in  1  start push button, already synchronised, level (not pulse)
levelselect  in  1  level switch, 0 = level 1, 1 = level 2
hit  in  1  player touched a wall or the border (collision output)
goal  in  1  player reached the end zone (collision output)
state  out  3  0 IDLE, 1 PLAY, 2 RESPAWN, 3 WIN, 4 LOSE
level  out  1  level latched at game start
play_en  out  1  1 only in PLAY; gates player movement
player_rst  out  1  one-clk pulse returning the player to the start position
lives  out  3  remaining lives
seconds  out  8  remaining time in seconds
show_win  out  1  1 in WIN
show_over  out  1  1 in LOSE

Behaviour:
- Reset values: state=IDLE; level=0; play_en=0; player_rst=1 on the reset cycle, then 0; lives=LIVES; seconds=TIME_LIMIT; show_win=0; show_over=0. All internal counters are cleared. rst overrides every other input in any state.
- start_evt is the rising edge of start, taken from a registered copy of start. A button held through reset does not produce an event.
- Outputs are registered and reflect the state one clk after the transition edge.
- IDLE:
  - level follows levelselect every clk.
  - On start_evt: lives←LIVES, seconds←TIME_LIMIT, frame_cnt←0, pulse player_rst, go to PLAY.
- PLAY:
  - play_en=1. Each update increments frame_cnt.
  - When frame_cnt reaches FRAMES_PER_SEC-1 on an update: frame_cnt←0 and seconds decrements.
  - Same-clk priority: goal, then hit, then timer expiry.
  - goal → WIN.
  - hit with lives>1 → lives−1, resp_cnt←0, go to RESPAWN.
  - hit with lives==1 → lives←0, go to LOSE.
  - seconds decrement reaching 0 → LOSE.
  - level is frozen; levelselect changes are ignored until the next IDLE.
- RESPAWN:
  - play_en=0, timer frozen, hit and goal ignored.
  - resp_cnt increments per update.
  - At RESPAWN_FRAMES updates: pulse player_rst, go to PLAY. The player reset happens at respawn exit, not entry, so the crash position stays visible while frozen.
- WIN / LOSE:
  - play_en=0; show_win or show_over=1.
  - hold_cnt increments per update and saturates at HOLD_FRAMES.
  - start_evt is ignored until hold_cnt==HOLD_FRAMES, then returns to IDLE. On that transition seconds and lives keep their final values until the next game start.
- update coinciding with a state transition is consumed by the new state's counter only if that counter is already active. A counter is never incremented in the entry cycle.
- seconds never wraps below 0. lives never wraps below 0.
- Illegal state encodings go to IDLE on the next clk.

Test Plan:
- Reset, then raise start → state=1, player_rst high for exactly 1 clk, lives=3, seconds=90, level equals levelselect at the start edge. Toggling levelselect during PLAY leaves level unchanged.
- PLAY with 60 update pulses → seconds=89. With 90×60 pulses and no hit or goal → state=4, seconds=0, show_over=1.
- Three hit pulses, each after the respawn completes:
  - 1st hit → state=2, lives=2; after 60 updates, player_rst pulse and state=1.
  - 2nd hit → lives=1, same respawn behaviour.
  - 3rd hit → state=4, lives=0.
- hit and goal in the same clk with lives=1 → state=3 (WIN); lives stays 1.
- In WIN: start pressed after 50 updates → ignored. Start released and pressed again after 120 updates → state=0.
- rst asserted mid-RESPAWN → next clk state=0, lives=3, seconds=90, play_en=0. Start held through reset gives no game start until it is released and pressed again.
